td4_sequencer: RTL and testbench

Parametrised fetch/execute sequencer that replaces the purely combinational TD4 opcode decoder. It owns the program counter, carry flag and instruction register. It fetches instructions through a valid-qualified memory handshake and drives the datapath's select and active-low load strobes for exactly one cycle per instruction. It adds HALT, illegal-opcode flagging, run/idle control and configurable data and address widths.

---
 rtl/td4_pkg.sv | 48 ++++
 rtl/td4_sequencer_if.sv | 14 +
 rtl/td4_op_decode.sv | 43 ++++
 rtl/td4_sequencer.sv | 85 ++++++++
 tb/tb_td4_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/td4_pkg.sv
// Shared types and encodings for the TD4 fetch/execute sequencer.
// Opcodes, ALU select codes, load-strobe bit positions and FSM states.
package td4_pkg;

    typedef enum logic [3:0] {
        OP_ADD_A   = 4'h0,
        OP_MOV_AB  = 4'h1,
        OP_IN_A    = 4'h2,
        OP_MOV_A   = 4'h3,
        OP_MOV_BA  = 4'h4,
        OP_ADD_B   = 4'h5,
        OP_IN_B    = 4'h6,
        OP_MOV_B   = 4'h7,
        OP_HALT    = 4'h8,
        OP_OUT_B   = 4'h9,
        OP_OUT_IMM = 4'hB,
        OP_JNC     = 4'hE,
        OP_JMP     = 4'hF
    } op_t;

    localparam logic [1:0] SEL_A    = 2'b00;
    localparam logic [1:0] SEL_B    = 2'b01;
    localparam logic [1:0] SEL_IN   = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;

    localparam logic [1:0] LD_A   = 2'd3;
    localparam logic [1:0] LD_B   = 2'd2;
    localparam logic [1:0] LD_OUT = 2'd1;
    localparam logic [1:0] LD_PC  = 2'd0;

    localparam logic [3:0] LD_NONE = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    // Active-low strobe vector with only the given load bit asserted.
    function automatic logic [3:0] ld_strobe(input logic [1:0] idx);
        logic [3:0] v;
        v      = LD_NONE;
        v[idx] = 1'b0;
        return v;
    endfunction

endpackage

// File: rtl/td4_sequencer_if.sv
// Instruction-memory fetch handshake between the sequencer and program store.
// The sequencer holds req/addr until valid is returned.
interface td4_sequencer_if #(
    parameter int DW = 4,
    parameter int AW = 4
) ();
    logic          req;
    logic [AW-1:0] addr;
    logic          valid;
    logic [DW+3:0] data;

    modport master (output req, output addr, input valid, input data);
    modport slave  (input req, input addr, output valid, output data);
endinterface

// File: rtl/td4_op_decode.sv
// Combinational TD4 opcode decoder: ALU select and active-low load strobes.
// Undefined opcodes decode as a NOP and raise is_illegal.
module td4_op_decode
    import td4_pkg::*;
(
    input  logic [3:0] op,
    input  logic       c_flag,
    output logic [1:0] sel,
    output logic [3:0] ld_n,
    output logic       is_halt,
    output logic       is_illegal
);

    always_comb begin
        sel        = SEL_A;
        ld_n       = LD_NONE;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (op)
            OP_ADD_A:   begin sel = SEL_A;    ld_n = ld_strobe(LD_A);   end
            OP_MOV_AB:  begin sel = SEL_B;    ld_n = ld_strobe(LD_A);   end
            OP_IN_A:    begin sel = SEL_IN;   ld_n = ld_strobe(LD_A);   end
            OP_MOV_A:   begin sel = SEL_ZERO; ld_n = ld_strobe(LD_A);   end
            OP_MOV_BA:  begin sel = SEL_A;    ld_n = ld_strobe(LD_B);   end
            OP_ADD_B:   begin sel = SEL_B;    ld_n = ld_strobe(LD_B);   end
            OP_IN_B:    begin sel = SEL_IN;   ld_n = ld_strobe(LD_B);   end
            OP_MOV_B:   begin sel = SEL_ZERO; ld_n = ld_strobe(LD_B);   end
            OP_OUT_B:   begin sel = SEL_B;    ld_n = ld_strobe(LD_OUT); end
            OP_OUT_IMM: begin sel = SEL_ZERO; ld_n = ld_strobe(LD_OUT); end
            OP_JMP:     begin sel = SEL_ZERO; ld_n = ld_strobe(LD_PC);  end
            OP_JNC: begin
                // Jump only when the previous instruction produced no carry.
                if (!c_flag) begin
                    sel  = SEL_ZERO;
                    ld_n = ld_strobe(LD_PC);
                end
            end
            OP_HALT: is_halt = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/td4_sequencer.sv
// TD4 fetch/execute sequencer: owns pc, carry flag and instruction register,
// fetches over a valid-qualified handshake and strobes the datapath in EXEC.
//
// state | meaning
// IDLE  | waiting for run before fetching
// FETCH | imem_req high at pc, waiting for imem_valid
// EXEC  | one cycle; decoded strobes drive the datapath, pc/c_flag update
// HALT  | terminal after HALT opcode until reset
module td4_sequencer
    import td4_pkg::*;
#(
    parameter int DW = 4,
    parameter int AW = 4    // AW must not exceed DW; jump targets come from imm
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    td4_sequencer_if.master       imem,
    input  logic                  alu_cout,
    output logic [1:0]            sel,
    output logic [3:0]            ld_n,
    output logic [DW-1:0]         imm,
    output logic                  halted,
    output logic                  illegal
);

    state_t        state;
    logic [AW-1:0] pc;
    logic          c_flag;
    logic [DW+3:0] ir;

    logic [1:0] dec_sel;
    logic [3:0] dec_ld_n;
    logic       dec_halt;
    logic       dec_illegal;
    logic       in_exec;

    td4_op_decode u_decode (
        .op         (ir[DW+3:DW]),
        .c_flag     (c_flag),
        .sel        (dec_sel),
        .ld_n       (dec_ld_n),
        .is_halt    (dec_halt),
        .is_illegal (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            pc     <= '0;
            c_flag <= 1'b0;
            ir     <= '0;
        end else begin
            case (state)
                ST_IDLE: if (run) state <= ST_FETCH;
                ST_FETCH: begin
                    if (imem.valid) begin
                        ir    <= imem.data;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    c_flag <= alu_cout;
                    pc     <= !dec_ld_n[LD_PC] ? ir[AW-1:0] : pc + AW'(1);
                    if (dec_halt)  state <= ST_HALT;
                    else if (run)  state <= ST_FETCH;
                    else           state <= ST_IDLE;
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Decoder outputs are forced inactive everywhere except the EXEC cycle.
    assign in_exec   = (state == ST_EXEC);
    assign imem.req  = (state == ST_FETCH);
    assign imem.addr = pc;
    assign sel       = in_exec ? dec_sel : SEL_A;
    assign ld_n      = in_exec ? dec_ld_n : LD_NONE;
    assign imm       = in_exec ? ir[DW-1:0] : '0;
    assign illegal   = in_exec & dec_illegal;
    assign halted    = (state == ST_HALT);

endmodule

// File: tb/tb_td4_sequencer.sv
// Self-checking bench for td4_sequencer: directed scenarios plus a random
// instruction stream checked against a behavioural pc/carry model.
module tb_td4_sequencer;

    localparam int DW = 4;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run = 1'b0;
    logic          alu_cout = 1'b0;
    logic [1:0]    sel;
    logic [3:0]    ld_n;
    logic [DW-1:0] imm;
    logic          halted;
    logic          illegal;

    int checks = 0;
    int errors = 0;
    logic [3:0] m_pc;
    logic       m_c;

    td4_sequencer_if #(.DW(DW), .AW(AW)) imem ();

    td4_sequencer #(.DW(DW), .AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .imem     (imem),
        .alu_cout (alu_cout),
        .sel      (sel),
        .ld_n     (ld_n),
        .imm      (imm),
        .halted   (halted),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    // Opcode table: returns {illegal, sel, ld_n} for an EXEC cycle.
    function automatic logic [6:0] model_ctrl(input logic [3:0] op, input logic c);
        case (op)
            4'h0, 4'h1, 4'h2, 4'h3: return {1'b0, op[1:0], 4'b0111};
            4'h4: return {1'b0, 2'b00, 4'b1011};
            4'h5: return {1'b0, 2'b01, 4'b1011};
            4'h6: return {1'b0, 2'b10, 4'b1011};
            4'h7: return {1'b0, 2'b11, 4'b1011};
            4'h9: return {1'b0, 2'b01, 4'b1101};
            4'hB: return {1'b0, 2'b11, 4'b1101};
            4'hE: return c ? {1'b0, 2'b00, 4'b1111} : {1'b0, 2'b11, 4'b1110};
            4'hF: return {1'b0, 2'b11, 4'b1110};
            4'h8: return {1'b0, 2'b00, 4'b1111};
            default: return {1'b1, 2'b00, 4'b1111};
        endcase
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        run = 1'b0;
        imem.valid = 1'b0;
        imem.data = '0;
        alu_cout = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_pc = 4'd0;
        m_c = 1'b0;
    endtask

    // Serves one fetch (with wait cycles) and captures the EXEC-cycle outputs.
    task automatic fetch_exec(input logic [7:0] instr, input int wait_n,
                              input logic run_wait, input logic cout, input logic drop_run,
                              output logic [1:0] o_sel, output logic [3:0] o_ld,
                              output logic [3:0] o_imm, output logic o_ill,
                              output logic [3:0] o_addr, output logic o_ok);
        int n;
        o_ok = 1'b1;
        n = 0;
        while (imem.req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (imem.req !== 1'b1) o_ok = 1'b0;
        o_addr = imem.addr;
        for (int i = 0; i < wait_n; i++) begin
            run = run_wait;
            imem.valid = 1'b0;
            @(negedge clk);
            if (imem.req !== 1'b1 || imem.addr !== o_addr || ld_n !== 4'hF) o_ok = 1'b0;
        end
        imem.valid = 1'b1;
        imem.data = instr;
        @(negedge clk);
        imem.valid = 1'b0;
        imem.data = 8'($urandom);
        o_sel = sel;
        o_ld = ld_n;
        o_imm = imm;
        o_ill = illegal;
        alu_cout = cout;
        run = ~drop_run;
        @(negedge clk);
        alu_cout = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({imem.req, imem.addr} !== 5'b0) begin
            errors++;
            $display("FAIL reset_fetch got req=%b addr=%h exp 0 0", imem.req, imem.addr);
        end
        checks++;
        if ({sel, ld_n, imm} !== {2'b00, 4'hF, 4'h0}) begin
            errors++;
            $display("FAIL reset_ctrl got sel=%b ld_n=%b imm=%h exp 00 1111 0", sel, ld_n, imm);
        end
        checks++;
        if ({halted, illegal} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags got halted=%b illegal=%b exp 0 0", halted, illegal);
        end
    endtask

    task automatic test_basic();
        logic [1:0] s; logic [3:0] l, im, a; logic il, ok;
        do_reset();
        run = 1'b1;
        fetch_exec(8'h35, 0, 1'b1, 1'b0, 1'b0, s, l, im, il, a, ok);
        checks++;
        if ({ok, a, s, l, im} !== {1'b1, 4'd0, 2'b11, 4'b0111, 4'd5}) begin
            errors++;
            $display("FAIL basic_mov ok=%b addr=%0d sel=%b ld_n=%b imm=%0d exp 1 0 11 0111 5", ok, a, s, l, im);
        end
        fetch_exec(8'h03, 0, 1'b1, 1'b0, 1'b0, s, l, im, il, a, ok);
        checks++;
        if ({ok, a, s, l, im} !== {1'b1, 4'd1, 2'b00, 4'b0111, 4'd3}) begin
            errors++;
            $display("FAIL basic_add ok=%b addr=%0d sel=%b ld_n=%b imm=%0d exp 1 1 00 0111 3", ok, a, s, l, im);
        end
        checks++;
        if ({imem.req, imem.addr} !== {1'b1, 4'd2}) begin
            errors++;
            $display("FAIL basic_pc got req=%b addr=%0d exp 1 2", imem.req, imem.addr);
        end
    endtask

    task automatic test_jnc();
        logic [1:0] s; logic [3:0] l, im, a; logic il, ok;
        do_reset();
        run = 1'b1;
        fetch_exec(8'h35, 0, 1'b1, 1'b1, 1'b0, s, l, im, il, a, ok);
        fetch_exec(8'hEA, 0, 1'b1, 1'b0, 1'b0, s, l, im, il, a, ok);
        checks++;
        if ({ok, a, s, l} !== {1'b1, 4'd1, 2'b00, 4'b1111}) begin
            errors++;
            $display("FAIL jnc_carry ok=%b addr=%0d sel=%b ld_n=%b exp 1 1 00 1111", ok, a, s, l);
        end
        fetch_exec(8'hEA, 0, 1'b1, 1'b0, 1'b0, s, l, im, il, a, ok);
        checks++;
        if ({ok, a, s, l} !== {1'b1, 4'd2, 2'b11, 4'b1110}) begin
            errors++;
            $display("FAIL jnc_nocarry ok=%b addr=%0d sel=%b ld_n=%b exp 1 2 11 1110", ok, a, s, l);
        end
        checks++;
        if (imem.addr !== 4'd10) begin
            errors++;
            $display("FAIL jnc_target got addr=%0d exp 10", imem.addr);
        end
    endtask

    task automatic test_wrap();
        logic [1:0] s; logic [3:0] l, im, a; logic il, ok;
        do_reset();
        run = 1'b1;
        fetch_exec(8'hFF, 0, 1'b1, 1'b0, 1'b0, s, l, im, il, a, ok);
        fetch_exec(8'h01, 0, 1'b1, 1'b0, 1'b0, s, l, im, il, a, ok);
        checks++;
        if ({ok, a, imem.addr} !== {1'b1, 4'd15, 4'd0}) begin
            errors++;
            $display("FAIL pc_wrap ok=%b exec_addr=%0d next_addr=%0d exp 1 15 0", ok, a, imem.addr);
        end
        fetch_exec(8'h35, 0, 1'b1, 1'b0, 1'b0, s, l, im, il, a, ok);
        fetch_exec(8'hF0, 0, 1'b1, 1'b0, 1'b0, s, l, im, il, a, ok);
        checks++;
        if ({ok, a, imem.addr} !== {1'b1, 4'd1, 4'd0}) begin
            errors++;
            $display("FAIL jmp_zero ok=%b exec_addr=%0d next_addr=%0d exp 1 1 0", ok, a, imem.addr);
        end
    endtask

    task automatic test_handshake();
        logic [1:0] s; logic [3:0] l, im, a; logic il, ok;
        do_reset();
        run = 1'b1;
        // run dropped while fetch is pending must not abort it
        fetch_exec(8'h9C, 3, 1'b0, 1'b0, 1'b0, s, l, im, il, a, ok);
        checks++;
        if ({ok, a, s, l, im} !== {1'b1, 4'd0, 2'b01, 4'b1101, 4'hC}) begin
            errors++;
            $display("FAIL handshake_wait ok=%b addr=%0d sel=%b ld_n=%b imm=%h exp 1 0 01 1101 c", ok, a, s, l, im);
        end
        checks++;
        if ({imem.req, imem.addr} !== {1'b1, 4'd1}) begin
            errors++;
            $display("FAIL handshake_next got req=%b addr=%0d exp 1 1", imem.req, imem.addr);
        end
    endtask

    task automatic test_halt_illegal();
        logic [1:0] s; logic [3:0] l, im, a; logic il, ok, stuck;
        do_reset();
        run = 1'b1;
        fetch_exec(8'hA5, 0, 1'b1, 1'b0, 1'b0, s, l, im, il, a, ok);
        checks++;
        if ({ok, il, s, l, im} !== {1'b1, 1'b1, 2'b00, 4'b1111, 4'd5}) begin
            errors++;
            $display("FAIL illegal_exec ok=%b ill=%b sel=%b ld_n=%b imm=%0d exp 1 1 00 1111 5", ok, il, s, l, im);
        end
        checks++;
        if ({illegal, imem.addr} !== {1'b0, 4'd1}) begin
            errors++;
            $display("FAIL illegal_after got illegal=%b addr=%0d exp 0 1", illegal, imem.addr);
        end
        fetch_exec(8'h80, 0, 1'b1, 1'b0, 1'b0, s, l, im, il, a, ok);
        checks++;
        if ({ok, il, s, l} !== {1'b1, 1'b0, 2'b00, 4'b1111}) begin
            errors++;
            $display("FAIL halt_exec ok=%b ill=%b sel=%b ld_n=%b exp 1 0 00 1111", ok, il, s, l);
        end
        stuck = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (halted !== 1'b1 || imem.req !== 1'b0 || ld_n !== 4'hF) stuck = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (stuck !== 1'b1) begin
            errors++;
            $display("FAIL halt_hold got halted=%b req=%b exp halted held with req 0", halted, imem.req);
        end
        do_reset();
        checks++;
        if ({halted, imem.req, imem.addr} !== {1'b0, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL halt_reset got halted=%b req=%b addr=%0d exp 0 0 0", halted, imem.req, imem.addr);
        end
    endtask

    task automatic test_mid_reset();
        logic [1:0] s; logic [3:0] l, im, a; logic il, ok, quiet;
        int n;
        do_reset();
        run = 1'b1;
        fetch_exec(8'h33, 0, 1'b1, 1'b0, 1'b0, s, l, im, il, a, ok);
        rst_n = 1'b0;
        imem.valid = 1'b1;
        imem.data = 8'h35;
        @(negedge clk);
        checks++;
        if ({imem.req, imem.addr, ld_n, sel, imm, halted, illegal} !== {1'b0, 4'd0, 4'hF, 2'b00, 4'd0, 2'b00}) begin
            errors++;
            $display("FAIL fetch_reset req=%b addr=%0d ld_n=%b sel=%b imm=%0d halted=%b illegal=%b exp reset values",
                     imem.req, imem.addr, ld_n, sel, imm, halted, illegal);
        end
        rst_n = 1'b1;
        imem.valid = 1'b0;
        run = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ld_n !== 4'hF || imem.req !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (quiet !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle got ld_n=%b req=%b exp 1111 0", ld_n, imem.req);
        end
        // Reset on the edge ending EXEC must block the carry update.
        run = 1'b1;
        n = 0;
        while (imem.req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        imem.valid = 1'b1;
        imem.data = 8'h35;
        @(negedge clk);
        imem.valid = 1'b0;
        rst_n = 1'b0;
        alu_cout = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        alu_cout = 1'b0;
        fetch_exec(8'hE7, 0, 1'b1, 1'b0, 1'b0, s, l, im, il, a, ok);
        checks++;
        if ({ok, a, s, l, imem.addr} !== {1'b1, 4'd0, 2'b11, 4'b1110, 4'd7}) begin
            errors++;
            $display("FAIL exec_reset ok=%b addr=%0d sel=%b ld_n=%b next=%0d exp 1 0 11 1110 7", ok, a, s, l, imem.addr);
        end
    endtask

    task automatic test_random();
        logic [1:0] s; logic [3:0] l, im, a; logic il, ok;
        logic [3:0] op, ri;
        logic [6:0] e;
        logic cout, drop;
        do_reset();
        run = 1'b1;
        for (int k = 0; k < 60; k++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'h8) op = 4'hE;
            ri = 4'($urandom);
            cout = 1'($urandom);
            drop = ($urandom_range(0, 7) == 0);
            e = model_ctrl(op, m_c);
            fetch_exec({op, ri}, int'($urandom_range(0, 2)), 1'($urandom), cout, drop, s, l, im, il, a, ok);
            checks++;
            if ({ok, a, il, s, l, im} !== {1'b1, m_pc, e, ri}) begin
                errors++;
                $display("FAIL rand_exec k=%0d op=%h ok=%b addr=%0d ill=%b sel=%b ld_n=%b imm=%h exp addr=%0d ctrl=%b imm=%h",
                         k, op, ok, a, il, s, l, im, m_pc, e, ri);
            end
            m_pc = (e[0] == 1'b0) ? ri : m_pc + 4'd1;
            m_c = cout;
            checks++;
            if ({imem.req, imem.addr} !== {~drop, m_pc}) begin
                errors++;
                $display("FAIL rand_next k=%0d req=%b addr=%0d exp %b %0d", k, imem.req, imem.addr, ~drop, m_pc);
            end
            run = 1'b1;
        end
    endtask

    initial begin
        imem.valid = 1'b0;
        imem.data = '0;
        test_reset();
        test_basic();
        test_jnc();
        test_wrap();
        test_handshake();
        test_halt_illegal();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
